// File: rtl/pool_relu_2x2.sv
// pool_relu_2x2: streaming 2x2 stride-2 max-pooling of a raster-order feature map.
// Optional build macro POOL_RELU_EN clamps every accepted sample at zero before pooling.
module pool_relu_2x2 #(
   parameter int I_BW    = 24,
   parameter int O_BW    = 24,
   parameter int IF_SIZE = 8
) (
   input  logic                   clk,
   input  logic                   global_rst_n,
   input  logic                   rst,
   input  logic                   ce,
   input  logic signed [I_BW-1:0] i_data,
   input  logic                   i_valid,
   output logic signed [O_BW-1:0] o_data,
   output logic                   o_valid,
   output logic                   o_end
);

   localparam int HALF = IF_SIZE / 2;
   localparam int CW   = $clog2(IF_SIZE);
   localparam int LW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] LAST = CW'(IF_SIZE - 1);

   generate
      if ((IF_SIZE % 2) != 0 || IF_SIZE < 2) begin : g_bad_size
         $error("pool_relu_2x2: IF_SIZE must be even and at least 2");
      end
      if (O_BW < I_BW) begin : g_bad_width
         $error("pool_relu_2x2: O_BW must not be narrower than I_BW");
      end
   endgenerate

   logic [CW-1:0]          col;
   logic [CW-1:0]          row;
   logic [LW-1:0]          idx;
   logic                   accept;
   logic signed [I_BW-1:0] hmax;
   logic signed [I_BW-1:0] sample;
   logic signed [I_BW-1:0] h;
   logic signed [I_BW-1:0] line_val;
   logic signed [I_BW-1:0] pooled;
   logic signed [I_BW-1:0] lbuf [HALF];

   // Two signed compares in series feed the single output register.
   always_comb begin
      accept = ce && i_valid;
      idx    = LW'(col >> 1);
`ifdef POOL_RELU_EN
      sample = i_data[I_BW-1] ? '0 : i_data;
`else
      sample = i_data;
`endif
      h        = (sample > hmax) ? sample : hmax;
      line_val = lbuf[idx];
      pooled   = (line_val > h) ? line_val : h;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge global_rst_n) begin
      if (!global_rst_n) begin
         col     <= '0;
         row     <= '0;
         hmax    <= '0;
         o_data  <= '0;
         o_valid <= 1'b0;
         o_end   <= 1'b0;
      end else if (rst) begin
         col     <= '0;
         row     <= '0;
         hmax    <= '0;
         o_data  <= '0;
         o_valid <= 1'b0;
         o_end   <= 1'b0;
      end else begin
         // Pulses drop every cycle, including stalls, so one input never yields two outputs.
         o_valid <= 1'b0;
         o_end   <= 1'b0;
         if (accept) begin
            if (!col[0]) begin
               hmax <= sample;
            end else if (row[0]) begin
               o_data  <= O_BW'(pooled);
               o_valid <= 1'b1;
               o_end   <= (row == LAST) && (col == LAST);
            end
            if (col == LAST) begin
               col <= '0;
               row <= (row == LAST) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   // NOTE: the line buffer has no reset; an even row always rewrites an entry before an odd row reads it.
   always_ff @(posedge clk) begin
      if (accept && col[0] && !row[0]) begin
         lbuf[idx] <= h;
      end
   end

endmodule

// File: tb/tb_pool_relu_2x2.sv
// tb_pool_relu_2x2: self-checking bench for pool_relu_2x2 against a frame-array reference model.
// Honors POOL_RELU_EN the same way the design does.
module tb_pool_relu_2x2;

   localparam int I_BW    = 24;
   localparam int O_BW    = 24;
   localparam int IF_SIZE = 8;
   localparam int NPIX    = IF_SIZE * IF_SIZE;
   localparam int NOUT    = (IF_SIZE / 2) * (IF_SIZE / 2);
`ifdef POOL_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   logic                   clk = 1'b0;
   logic                   global_rst_n;
   logic                   rst;
   logic                   ce;
   logic signed [I_BW-1:0] i_data;
   logic                   i_valid;
   logic signed [O_BW-1:0] o_data;
   logic                   o_valid;
   logic                   o_end;

   always #5 clk = ~clk;

   pool_relu_2x2 #(.I_BW(I_BW), .O_BW(O_BW), .IF_SIZE(IF_SIZE)) dut (
      .clk          (clk),
      .global_rst_n (global_rst_n),
      .rst          (rst),
      .ce           (ce),
      .i_data       (i_data),
      .i_valid      (i_valid),
      .o_data       (o_data),
      .o_valid      (o_valid),
      .o_end        (o_end)
   );

   typedef struct {
      int a;          // even row, even col
      int b;          // even row, odd col
      int c;          // odd row, even col
      int d;          // odd row, odd col
      int exp_plain;
      int exp_relu;
   } win_t;

   int     n_cmp = 0;
   int     n_bad = 0;
   int     pix [NPIX];
   int     pos;
   longint exp_data;
   bit     exp_v;
   bit     exp_e;
   longint got [$];
   int     n_end;

   task automatic check(input string name, input longint act, input longint req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0d, required %0d", name, $time, act, req);
      end
   endtask

   function automatic int relu(input int v);
      return (RELU && v < 0) ? 0 : v;
   endfunction

   function automatic int max2(input int x, input int y);
      return (x > y) ? x : y;
   endfunction

   task automatic model_reset();
      pos      = 0;
      exp_data = 0;
      exp_v    = 1'b0;
      exp_e    = 1'b0;
   endtask

   // Reference: store the frame, and at each window's last pixel take the max of its four pixels.
   task automatic model_edge(input bit c, input bit v, input int d);
      int r;
      int cc;
      if (!global_rst_n || rst) begin
         model_reset();
      end else begin
         exp_v = 1'b0;
         exp_e = 1'b0;
         if (c && v) begin
            r  = pos / IF_SIZE;
            cc = pos % IF_SIZE;
            pix[pos] = relu(d);
            if ((r % 2) == 1 && (cc % 2) == 1) begin
               exp_data = max2(max2(pix[pos], pix[pos-1]),
                               max2(pix[pos-IF_SIZE], pix[pos-IF_SIZE-1]));
               exp_v = 1'b1;
               exp_e = (pos == NPIX - 1);
            end
            pos = (pos + 1) % NPIX;
         end
      end
   endtask

   task automatic step(input bit c, input bit v, input int d);
      ce      = c;
      i_valid = v;
      i_data  = I_BW'(d);
      model_edge(c, v, d);
      @(posedge clk);
      #1;
      check("o_valid", o_valid, exp_v);
      check("o_end", o_end, exp_e);
      check("o_data", o_data, exp_data);
      if (o_valid) got.push_back(o_data);
      if (o_end) n_end++;
   endtask

   task automatic feed(input int base, input int count, input bit gaps);
      int k = 0;
      int cyc = 0;
      while (k < count) begin
         cyc++;
         if (gaps && (cyc % 3) == 0) begin
            step(1'b1, 1'b0, 0);
         end else begin
            step(1'b1, 1'b1, base + k);
            k++;
         end
      end
   endtask

   task automatic check_ramp(input string name, input int base, input int frames);
      int idx;
      check({name, " count"}, got.size(), NOUT * frames);
      check({name, " ends"}, n_end, frames);
      for (int f = 0; f < frames; f++) begin
         for (int i = 0; i < NOUT; i++) begin
            idx = f * NOUT + i;
            if (idx < got.size())
               check(name, got[idx],
                     base + f * NPIX + (2 * (i / 4) + 1) * IF_SIZE + 2 * (i % 4) + 1);
         end
      end
      got.delete();
      n_end = 0;
   endtask

   win_t vec [7];

   initial begin
      vec[0] = '{a: -5, b: -3, c: -7, d: -9, exp_plain: -3, exp_relu: 0};
      vec[1] = '{a: -1, b: 4, c: 2, d: -8, exp_plain: 4, exp_relu: 4};
      vec[2] = '{a: -8388608, b: 8388607, c: 0, d: 0, exp_plain: 8388607, exp_relu: 8388607};
      vec[3] = '{a: -8388608, b: -8388608, c: -8388608, d: -8388608,
                 exp_plain: -8388608, exp_relu: 0};
      vec[4] = '{a: 7, b: 7, c: 7, d: 7, exp_plain: 7, exp_relu: 7};
      vec[5] = '{a: 100, b: -100, c: 200, d: 50, exp_plain: 200, exp_relu: 200};
      vec[6] = '{a: -2, b: -6, c: -1, d: -4, exp_plain: -1, exp_relu: 0};

      global_rst_n = 1'b0;
      rst          = 1'b0;
      ce           = 1'b0;
      i_valid      = 1'b0;
      i_data       = '0;
      model_reset();
      n_end = 0;
      #7;
      check("reset o_data", o_data, 0);
      check("reset o_valid", o_valid, 0);
      check("reset o_end", o_end, 0);
      global_rst_n = 1'b1;

      // Ramp, continuous valid.
      feed(0, NPIX, 1'b0);
      check_ramp("ramp", 0, 1);

      // Ramp with periodic gaps and a 5-cycle ce stall in row 3.
      feed(0, 28, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 999);
      feed(28, NPIX - 28, 1'b1);
      check_ramp("stall ramp", 0, 1);

      // Two frames back to back.
      feed(0, 2 * NPIX, 1'b0);
      check_ramp("b2b", 0, 2);

      // Window vectors, each replicated over a whole frame.
      for (int t = 0; t < 7; t++) begin
         for (int p = 0; p < NPIX; p++) begin
            case (((p / IF_SIZE) % 2) * 2 + (p % 2))
               0:       step(1'b1, 1'b1, vec[t].a);
               1:       step(1'b1, 1'b1, vec[t].b);
               2:       step(1'b1, 1'b1, vec[t].c);
               default: step(1'b1, 1'b1, vec[t].d);
            endcase
         end
         check("window count", got.size(), NOUT);
         for (int i = 0; i < got.size(); i++)
            check("window value", got[i], RELU ? vec[t].exp_relu : vec[t].exp_plain);
         got.delete();
         n_end = 0;
      end

      // Random frames against the model.
      for (int f = 0; f < 3; f++) begin
         for (int p = 0; p < NPIX; p++) begin
            if ($urandom_range(0, 4) == 0) step(1'b1, 1'b0, 0);
            if ($urandom_range(0, 9) == 0) step(1'b0, 1'b1, 0);
            step(1'b1, 1'b1, $urandom_range(0, 32'hFFFFFF) - 8388608);
         end
      end
      check("random ends", n_end, 3);
      got.delete();
      n_end = 0;

      // Asynchronous reset mid-frame.
      feed(0, 37, 1'b0);
      #2;
      global_rst_n = 1'b0;
      model_reset();
      #1;
      check("async rst o_data", o_data, 0);
      check("async rst o_valid", o_valid, 0);
      check("async rst o_end", o_end, 0);
      step(1'b1, 1'b1, 555);
      step(1'b1, 1'b1, 556);
      global_rst_n = 1'b1;
      got.delete();
      n_end = 0;
      feed(0, NPIX, 1'b0);
      check_ramp("after async rst", 0, 1);

      // Synchronous clear mid-frame: nothing changes until the edge.
      feed(0, 37, 1'b0);
      rst = 1'b1;
      #1;
      check("sync rst before edge", o_data, exp_data);
      step(1'b1, 1'b1, 777);
      rst = 1'b0;
      got.delete();
      n_end = 0;
      feed(0, NPIX, 1'b0);
      check_ramp("after sync rst", 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
